// File: rtl/cache_pkg.sv
// cache_pkg
// Shared types and constants for the cache miss-fill controller.
//   fill_state_t    : controller state encoding (IDLE, FILL)
//   WORDS_PER_BLOCK : 16-bit words per cache block
//   BLOCK_OFFSET_W  : byte-offset bits inside a block
//   WORD_IDX_W      : bits needed to index a word inside a block
//   word_index()    : word position inside the block for the n-th transfer
package cache_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

  localparam int WORDS_PER_BLOCK = 8;
  localparam int BLOCK_OFFSET_W  = 4;
  localparam int WORD_IDX_W      = 3;

  // Word position of transfer 'offset' when the fill starts at word 'start'.
  // The sum is WORD_IDX_W bits wide, so it wraps around the block naturally.
  function automatic logic [WORD_IDX_W-1:0] word_index(
    input logic [WORD_IDX_W-1:0] start,
    input logic [WORD_IDX_W-1:0] offset
  );
    return start + offset;
  endfunction

endpackage

// File: rtl/fill_word_counter.sv
// fill_word_counter
// Word counter for one side (issue or return) of a block fill.
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   en     in   advance the count by one
//   clr    in   synchronous clear (wins over en)
//   count  out  current count, WORD_IDX_W bits
//   last   out  count is at its final value (all ones)
module fill_word_counter
  import cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  output logic [WORD_IDX_W-1:0] count,
  output logic                  last
);

  logic [WORD_IDX_W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;
  assign last  = &count_reg;

endmodule

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm
// Miss-handling controller between a cache's data/tag arrays and pipelined
// main memory. On a miss it issues one read per cycle for every word of the
// block, writes each returned word into the data array in issue order, and
// writes the tag together with the last returned word. The CPU is stalled
// through fsm_busy for the whole fill, including the miss cycle itself.
//
// Optional build macro: CACHE_FILL_CRITICAL_WORD_FIRST_EN
//   defined   : the fill starts at the missing word and wraps around the
//               block; output crit_word_ready flags the first data write.
//   undefined : words are always fetched 0..7; crit_word_ready is absent.
//
// Ports:
//   clk               in   system clock, rising edge
//   rst_n             in   asynchronous active-low reset
//   miss_detected     in   cache lookup missed this cycle
//   miss_address      in   byte address that missed
//   memory_data_valid in   one returned word this cycle (issue order)
//   memory_data       in   returned word
//   fsm_busy          out  stall request to the CPU
//   memory_read       out  issue one word read this cycle
//   memory_address    out  byte address of the issued read
//   write_data_array  out  data-array write enable
//   cache_word_addr   out  byte address of the data-array word written
//   cache_write_data  out  word to write (memory_data)
//   write_tag_array   out  tag-array write enable, one-cycle pulse
//   crit_word_ready   out  first data write of a fill (optional build only)
module cache_fill_fsm
  import cache_pkg::*;
#(
  parameter int MEM_LATENCY     = 4,
  parameter int WORDS_PER_BLOCK = 8,
  parameter int ADDR_W          = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              memory_data_valid,
  input  logic [15:0]       memory_data,
  output logic              fsm_busy,
  output logic              memory_read,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic [ADDR_W-1:0] cache_word_addr,
  output logic [15:0]       cache_write_data,
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
  output logic              crit_word_ready,
`endif
  output logic              write_tag_array
);

  // The word counters are sized from the package; reject configurations
  // they cannot cover. Memory latency only matters to the memory side, the
  // controller counts returns rather than cycles.
  if (WORDS_PER_BLOCK != (1 << WORD_IDX_W) || MEM_LATENCY < 1) begin : g_bad_params
    $error("cache_fill_fsm: unsupported WORDS_PER_BLOCK or MEM_LATENCY");
  end

  fill_state_t state_reg, state_next;

  // Only the block-aligned part of the address is kept; the offset bits of
  // every generated address come from the word index.
  logic [ADDR_W-1:BLOCK_OFFSET_W] base_reg;

  // Set once all words of the block have been issued, so the 3-bit issue
  // counter can wrap back to zero without re-issuing.
  logic issue_done_reg;

  logic [WORD_IDX_W-1:0] issue_cnt, recv_cnt, start_idx;
  logic [WORD_IDX_W-1:0] issue_idx, recv_idx;
  logic                  issue_last, recv_last;
  logic                  unused_offset_bits;

  assign unused_offset_bits = ^miss_address[BLOCK_OFFSET_W-1:0];

  fill_word_counter u_issue_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (memory_read),
    .clr   (write_tag_array),
    .count (issue_cnt),
    .last  (issue_last)
  );

  fill_word_counter u_recv_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (write_data_array),
    .clr   (write_tag_array),
    .count (recv_cnt),
    .last  (recv_last)
  );

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
  logic [WORD_IDX_W-1:0] start_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_reg <= '0;
    end else if (state_reg == IDLE && miss_detected) begin
      start_reg <= miss_address[BLOCK_OFFSET_W-1:1];
    end
  end

  assign start_idx = start_reg;

  // The return counter is still zero on the first write of each fill.
  assign crit_word_ready = write_data_array && (recv_cnt == '0);
`else
  assign start_idx = '0;
`endif

  assign issue_idx = word_index(start_idx, issue_cnt);
  assign recv_idx  = word_index(start_idx, recv_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      base_reg       <= '0;
      issue_done_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && miss_detected) begin
        base_reg <= miss_address[ADDR_W-1:BLOCK_OFFSET_W];
      end
      if (write_tag_array) begin
        issue_done_reg <= 1'b0;
      end else if (memory_read && issue_last) begin
        issue_done_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next       = state_reg;
    fsm_busy         = 1'b0;
    memory_read      = 1'b0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    case (state_reg)
      IDLE: begin
        // Combinational so the CPU already stalls in the miss cycle.
        fsm_busy = miss_detected;
        if (miss_detected) begin
          state_next = FILL;
        end
      end
      FILL: begin
        fsm_busy         = 1'b1;
        memory_read      = !issue_done_reg;
        write_data_array = memory_data_valid;
        if (memory_data_valid && recv_last) begin
          write_tag_array = 1'b1;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Addresses and data are forced to zero outside their strobes so idle
  // outputs are quiet.
  assign memory_address   = memory_read ? {base_reg, issue_idx, 1'b0} : '0;
  assign cache_word_addr  = write_data_array ? {base_reg, recv_idx, 1'b0} : '0;
  assign cache_write_data = write_data_array ? memory_data : '0;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm
// Bench for cache_fill_fsm: a pipelined memory model (fixed latency, with
// optional stall) answers the issued reads with data = address ^ 16'hA5A5.
// Expected read and write addresses are queued when a miss is driven and
// popped as the controller issues reads and writes the data array.
module tb_cache_fill_fsm;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        fsm_busy;
  logic        memory_read;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [15:0] cache_word_addr;
  logic [15:0] cache_write_data;
  logic        write_tag_array;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
  logic        crit_word_ready;
  logic        obs_crit;
`endif

  cache_fill_fsm #(
    .MEM_LATENCY     (LAT),
    .WORDS_PER_BLOCK (8),
    .ADDR_W          (16)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .fsm_busy          (fsm_busy),
    .memory_read       (memory_read),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .cache_word_addr   (cache_word_addr),
    .cache_write_data  (cache_write_data),
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    .crit_word_ready   (crit_word_ready),
`endif
    .write_tag_array   (write_tag_array)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [15:0] mem_addr_q[$];
  int          mem_due_q[$];
  logic [15:0] exp_rd_q[$];
  logic [15:0] exp_wr_q[$];

  logic        obs_busy, obs_rd, obs_wr, obs_tag;
  logic [15:0] obs_maddr;

  // Queue the eight block addresses a miss at maddr must produce.
  task automatic push_fill(input logic [15:0] maddr);
    logic [15:0] blk;
    int          w;
    blk = maddr & 16'hFFF0;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    w = int'(maddr[3:1]);
`else
    w = 0;
`endif
    for (int i = 0; i < 8; i++) begin
      exp_rd_q.push_back(blk + 16'(((w + i) % 8) * 2));
      exp_wr_q.push_back(blk + 16'(((w + i) % 8) * 2));
    end
  endtask

  // One clock cycle: drive inputs just after the rising edge, sample the
  // outputs on the falling edge, score reads/writes, feed the memory model.
  task automatic run_cycle(input logic miss, input logic [15:0] maddr, input logic stall);
    logic [15:0] exp_a;
    miss_detected = miss;
    miss_address  = maddr;
    if (!stall && mem_due_q.size() > 0 && mem_due_q[0] <= cyc) begin
      memory_data_valid = 1'b1;
      memory_data       = mem_addr_q.pop_front() ^ 16'hA5A5;
      void'(mem_due_q.pop_front());
    end else begin
      memory_data_valid = 1'b0;
      memory_data       = 16'h0000;
    end
    @(negedge clk);
    obs_busy  = fsm_busy;
    obs_rd    = memory_read;
    obs_wr    = write_data_array;
    obs_tag   = write_tag_array;
    obs_maddr = memory_address;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    obs_crit  = crit_word_ready;
`endif
    if (memory_read) begin
      checks++;
      if (exp_rd_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected cyc=%0d got read addr=%h, expected no read", cyc, memory_address);
      end else begin
        exp_a = exp_rd_q.pop_front();
        if (memory_address !== exp_a) begin
          errors++;
          $display("FAIL rd_addr cyc=%0d got %h expected %h", cyc, memory_address, exp_a);
        end
      end
      mem_addr_q.push_back(memory_address);
      mem_due_q.push_back(cyc + LAT);
    end
    if (write_data_array) begin
      $display("cyc %0d write addr=%h data=%h tag=%b", cyc, cache_word_addr, cache_write_data,
               write_tag_array);
      checks++;
      if (exp_wr_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected cyc=%0d got write addr=%h, expected no write", cyc, cache_word_addr);
      end else begin
        exp_a = exp_wr_q.pop_front();
        if (cache_word_addr !== exp_a || cache_write_data !== (exp_a ^ 16'hA5A5)) begin
          errors++;
          $display("FAIL wr_word cyc=%0d got addr=%h data=%h expected addr=%h data=%h",
                   cyc, cache_word_addr, cache_write_data, exp_a, exp_a ^ 16'hA5A5);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst_n             = 1'b0;
    miss_detected     = 1'b0;
    miss_address      = 16'h0000;
    memory_data_valid = 1'b0;
    memory_data       = 16'h0000;
    repeat (3) @(negedge clk);
    checks++;
    if ({fsm_busy, memory_read, write_data_array, write_tag_array,
         memory_address, cache_word_addr, cache_write_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b rd=%b wr=%b tag=%b maddr=%h waddr=%h wdata=%h expected all 0",
               fsm_busy, memory_read, write_data_array, write_tag_array,
               memory_address, cache_word_addr, cache_write_data);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    cyc = 0;
    for (int c = 0; c < 16; c++) begin
      if (c == 0) push_fill(16'h1234);
      run_cycle(c == 0, 16'h1234, 1'b0);
      checks++;
      if (obs_busy !== (c <= 12)) begin
        errors++; $display("FAIL basic_busy cyc=%0d got %b expected %b", c, obs_busy, c <= 12);
      end
      checks++;
      if (obs_rd !== (c >= 1 && c <= 8)) begin
        errors++; $display("FAIL basic_read cyc=%0d got %b expected %b", c, obs_rd, c >= 1 && c <= 8);
      end
      checks++;
      if (obs_wr !== (c >= 5 && c <= 12)) begin
        errors++; $display("FAIL basic_write cyc=%0d got %b expected %b", c, obs_wr, c >= 5 && c <= 12);
      end
      checks++;
      if (obs_tag !== (c == 12)) begin
        errors++; $display("FAIL basic_tag cyc=%0d got %b expected %b", c, obs_tag, c == 12);
      end
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
      checks++;
      if (obs_crit !== (c == 5)) begin
        errors++; $display("FAIL basic_crit cyc=%0d got %b expected %b", c, obs_crit, c == 5);
      end
`endif
    end
    checks++;
    if (exp_wr_q.size() != 0) begin
      errors++; $display("FAIL basic_left got %0d pending writes expected 0", exp_wr_q.size());
    end
  endtask

  task automatic test_ignored_miss();
    int tags = 0;
    cyc = 0;
    for (int c = 0; c < 15; c++) begin
      if (c == 0) push_fill(16'h1234);
      run_cycle(c == 0 || c == 3, (c == 3) ? 16'h5000 : 16'h1234, 1'b0);
      if (obs_tag) tags++;
      checks++;
      if (obs_busy !== (c <= 12)) begin
        errors++; $display("FAIL ignmiss_busy cyc=%0d got %b expected %b", c, obs_busy, c <= 12);
      end
    end
    checks++;
    if (tags != 1) begin
      errors++; $display("FAIL ignmiss_tags got %0d tag pulses expected 1", tags);
    end
    checks++;
    if (exp_wr_q.size() != 0) begin
      errors++; $display("FAIL ignmiss_left got %0d pending writes expected 0", exp_wr_q.size());
    end
  endtask

  task automatic test_stall();
    cyc = 0;
    for (int c = 0; c < 25; c++) begin
      if (c == 0) push_fill(16'h2468);
      run_cycle(c == 0, 16'h2468, c >= 9 && c <= 18);
      checks++;
      if (obs_busy !== (c <= 22)) begin
        errors++; $display("FAIL stall_busy cyc=%0d got %b expected %b", c, obs_busy, c <= 22);
      end
      checks++;
      if (obs_wr !== ((c >= 5 && c <= 8) || (c >= 19 && c <= 22))) begin
        errors++; $display("FAIL stall_write cyc=%0d got %b expected %b", c, obs_wr,
                           (c >= 5 && c <= 8) || (c >= 19 && c <= 22));
      end
      checks++;
      if (obs_tag !== (c == 22)) begin
        errors++; $display("FAIL stall_tag cyc=%0d got %b expected %b", c, obs_tag, c == 22);
      end
    end
    checks++;
    if (exp_wr_q.size() != 0) begin
      errors++; $display("FAIL stall_left got %0d pending writes expected 0", exp_wr_q.size());
    end
  endtask

  task automatic test_reset_midfill();
    cyc = 0;
    for (int c = 0; c < 14; c++) begin
      if (c == 0) push_fill(16'h1234);
      if (c == 6) begin
        rst_n = 1'b0;
        #1;
        checks++;
        if ({fsm_busy, memory_read, write_data_array, write_tag_array,
             memory_address, cache_word_addr, cache_write_data} !== '0) begin
          errors++;
          $display("FAIL midreset_outputs got busy=%b rd=%b wr=%b tag=%b expected all 0",
                   fsm_busy, memory_read, write_data_array, write_tag_array);
        end
        exp_rd_q.delete();
        exp_wr_q.delete();
      end
      if (c == 8) rst_n = 1'b1;
      run_cycle(c == 0, 16'h1234, 1'b0);
      checks++;
      if (obs_busy !== (c <= 5)) begin
        errors++; $display("FAIL midreset_busy cyc=%0d got %b expected %b", c, obs_busy, c <= 5);
      end
      checks++;
      if (obs_wr !== (c == 5)) begin
        errors++; $display("FAIL midreset_write cyc=%0d got %b expected %b", c, obs_wr, c == 5);
      end
      checks++;
      if (obs_tag !== 1'b0) begin
        errors++; $display("FAIL midreset_tag cyc=%0d got %b expected 0", c, obs_tag);
      end
    end
    mem_addr_q.delete();
    mem_due_q.delete();
  endtask

  task automatic test_back_to_back();
    cyc = 0;
    for (int c = 0; c < 28; c++) begin
      if (c == 0)  push_fill(16'hFFFA);
      if (c == 13) push_fill(16'h0002);
      run_cycle(c == 0 || c == 13, (c == 13) ? 16'h0002 : 16'hFFFA, 1'b0);
      checks++;
      if (obs_busy !== (c <= 25)) begin
        errors++; $display("FAIL b2b_busy cyc=%0d got %b expected %b", c, obs_busy, c <= 25);
      end
      checks++;
      if (obs_rd !== ((c >= 1 && c <= 8) || (c >= 14 && c <= 21))) begin
        errors++; $display("FAIL b2b_read cyc=%0d got %b expected %b", c, obs_rd,
                           (c >= 1 && c <= 8) || (c >= 14 && c <= 21));
      end
      checks++;
      if (obs_tag !== (c == 12 || c == 25)) begin
        errors++; $display("FAIL b2b_tag cyc=%0d got %b expected %b", c, obs_tag, c == 12 || c == 25);
      end
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
      checks++;
      if (obs_crit !== (c == 5 || c == 18)) begin
        errors++; $display("FAIL b2b_crit cyc=%0d got %b expected %b", c, obs_crit, c == 5 || c == 18);
      end
`endif
    end
    checks++;
    if (exp_wr_q.size() != 0) begin
      errors++; $display("FAIL b2b_left got %0d pending writes expected 0", exp_wr_q.size());
    end
  endtask

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
  task automatic test_critical_word();
    logic [15:0] order [8];
    order = '{16'h123A, 16'h123C, 16'h123E, 16'h1230, 16'h1232, 16'h1234, 16'h1236, 16'h1238};
    cyc = 0;
    for (int c = 0; c < 15; c++) begin
      if (c == 0) push_fill(16'h123A);
      run_cycle(c == 0, 16'h123A, 1'b0);
      if (c >= 1 && c <= 8) begin
        checks++;
        if (obs_rd !== 1'b1 || obs_maddr !== order[c-1]) begin
          errors++; $display("FAIL cwf_order cyc=%0d got rd=%b addr=%h expected rd=1 addr=%h",
                             c, obs_rd, obs_maddr, order[c-1]);
        end
      end
      checks++;
      if (obs_crit !== (c == 5)) begin
        errors++; $display("FAIL cwf_crit cyc=%0d got %b expected %b", c, obs_crit, c == 5);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_ignored_miss();
    test_stall();
    test_reset_midfill();
    test_back_to_back();
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    test_critical_word();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
